mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; synchronous, active-low.
REQ-004 ex_valid  in  1  EX/MEM holds a live instruction.
REQ-005 ex_RegWrite, ex_ResultSrc, ex_MemWrite  in  1/2/1  EX/MEM control; ResultSrc 2'b01 = load.
REQ-006 ex_funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 ex_ALUResult, ex_WriteData, ex_ImmExt, ex_PCPlus4  in  32 each  EX/MEM data; ALUResult is the address.
REQ-008 ex_Rd  in  5  destination register.
REQ-009 dmem_req, dmem_we  out  1  bus request, write enable.
REQ-010 dmem_addr  out  32  word-aligned address {ALUResult[31:2],2'b00}.
REQ-011 dmem_be, dmem_wdata  out  4/32  byte enables, lane-replicated store data.
REQ-012 dmem_gnt, dmem_rvalid, dmem_rdata  in  1/1/32  grant, read-data valid, read data.
REQ-013 stall_o  out  1  freeze IF/ID/EX and EX/MEM this cycle.
REQ-014 misalign_o  out  1  one-cycle pulse: misaligned access dropped.
REQ-015 memwb  memwb_if.wr  --  registered MEM/WB ctrl {RegWrite, ResultSrc} and data {ALUResult, load_data, ImmExt, PCPlus4, Rd}.

Function
REQ-016 Memory op = ex_valid and (ex_MemWrite or ex_ResultSrc==01); all other inputs pass to MEM/WB at the next edge, load_data=0, latency 1, stall_o=0.
REQ-017 FSM states IDLE, RESP; RESP entered only for a granted load.
REQ-018 IDLE with aligned memory op: dmem_req=1 combinationally; dmem_we=ex_MemWrite.
REQ-019 IDLE, req and dmem_gnt=0: stall_o=1, stay IDLE, request held.
REQ-020 IDLE, store granted: no stall; MEM/WB loaded at that edge; stay IDLE.
REQ-021 IDLE, load granted: stall_o=1; go RESP.
REQ-022 RESP: dmem_req=0; stall_o=!dmem_rvalid; on rvalid load MEM/WB with extended data, go IDLE.
REQ-023 Whenever stall_o=1, MEM/WB ctrl is written as zero (bubble); data fields don't-care.
REQ-024 Upstream holds ex_* stable while stall_o=1; block uses them directly in RESP.
REQ-025 Store lanes: SB be=4'b0001<<addr[1:0], wdata={4{byte}}; SH be=0011/1100 by addr[1], wdata={2{half}}; SW be=1111.
REQ-026 Load extraction: byte by addr[1:0], half by addr[1]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-027 Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0; no request, no stall, misalign_o=1 that cycle, MEM/WB ctrl zeroed.
REQ-028 dmem_rvalid while IDLE is ignored; dmem_gnt while dmem_req=0 is ignored.
REQ-029 ex_valid=0 forces MEM/WB ctrl zero and no request.

Reset
REQ-030 rst_n=0 at an edge: FSM to IDLE, all MEM/WB ctrl and data fields 0.
REQ-031 During rst_n=0: dmem_req, dmem_we, stall_o, misalign_o = 0.
REQ-032 Reset in RESP abandons the load; later rvalid ignored.

Structure
REQ-033 Shared package holds funct3 load/store constants, ResultSrc encodings, FSM state enum.
REQ-034 One combinational sub-module load_extend (rdata, addr[1:0], funct3 -> 32-bit result).

Verification
REQ-035 ADD, ALUResult=0x10, Rd=5 -> next cycle memwb RegWrite=1, ALUResult=0x10, Rd=5, stall_o=0.
REQ-036 LB addr 0x103, gnt same cycle, rvalid next with rdata=0x80FF_FFFF -> load_data=0xFFFF_FF80, 1 stall cycle, one bubble.
REQ-037 SH addr 0x202, data 0x1234ABCD, gnt delayed 2 cycles -> be=1100, wdata=0xABCDABCD, stall_o=1 for 2 cycles, req held.
REQ-038 LW addr 0x301 -> misalign_o=1, dmem_req=0, memwb RegWrite=0.
REQ-039 LHU addr 0x2, rdata=0xF00D_0000 -> load_data=0x0000_F00D; LH same -> 0xFFFF_F00D.
REQ-040 rst_n low in RESP, then rvalid -> MEM/WB stays zero, FSM IDLE, no writeback.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and encodings for the MEM pipeline stage: funct3 access sizes,
// ResultSrc load encoding, FSM states and MEM/WB payload structs.
package mem_stage_pkg;

  localparam int unsigned XLEN_W = 32;
  localparam int unsigned RD_W   = 5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RS_LOAD = 2'b01;

  typedef enum logic {ST_IDLE, ST_RESP} state_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } memwb_ctrl_t;

  typedef struct packed {
    logic [XLEN_W-1:0] alu_result;
    logic [XLEN_W-1:0] load_data;
    logic [XLEN_W-1:0] imm_ext;
    logic [XLEN_W-1:0] pc_plus4;
    logic [RD_W-1:0]   rd;
  } memwb_data_t;

  // Halfword needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
    logic mis;
    mis = 1'b0;
    if ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) mis = 1'b1;
    if (funct3 == F3_W && addr != 2'b00) mis = 1'b1;
    return mis;
  endfunction

endpackage

// File: rtl/memwb_if.sv
// MEM/WB pipeline register bundle: control and data halves.
interface memwb_if;
  import mem_stage_pkg::*;

  memwb_ctrl_t ctrl;
  memwb_data_t data;

  modport wr (output ctrl, output data);
  modport rd (input ctrl, input data);
endinterface

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword from a read word and sign/zero-extends it.
module load_extend
  import mem_stage_pkg::*;
(
  input  logic [XLEN_W-1:0] rdata,
  input  logic [1:0]        addr,
  input  logic [2:0]        funct3,
  output logic [XLEN_W-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'h0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory requests, stalls for grant/response,
// and loads the MEM/WB register (bubbling control whenever it stalls).
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_RegWrite,
  input  logic [1:0]      ex_ResultSrc,
  input  logic            ex_MemWrite,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_ALUResult,
  input  logic [XLEN-1:0] ex_WriteData,
  input  logic [XLEN-1:0] ex_ImmExt,
  input  logic [XLEN-1:0] ex_PCPlus4,
  input  logic [4:0]      ex_Rd,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall_o,
  output logic            misalign_o,
  memwb_if.wr             memwb
);

  state_t            state;
  logic              idle;
  logic              mem_op;
  logic              mis;
  logic [XLEN-1:0]   load_ext;

  load_extend u_load_extend (
    .rdata  (dmem_rdata),
    .addr   (ex_ALUResult[1:0]),
    .funct3 (ex_funct3),
    .result (load_ext)
  );

  // Request, stall and lane steering; all forced low while in reset.
  always_comb begin
    idle       = (state == ST_IDLE);
    mem_op     = ex_valid & (ex_MemWrite | (ex_ResultSrc == RS_LOAD));
    mis        = is_misaligned(ex_funct3, ex_ALUResult[1:0]);
    dmem_req   = rst_n & idle & mem_op & ~mis;
    dmem_we    = dmem_req & ex_MemWrite;
    misalign_o = rst_n & idle & mem_op & mis;
    stall_o    = rst_n & ((dmem_req & (~dmem_gnt | ~ex_MemWrite)) |
                          (~idle & ~dmem_rvalid));
    dmem_addr  = {ex_ALUResult[XLEN-1:2], 2'b00};
    dmem_be    = 4'b0000;
    dmem_wdata = ex_WriteData;
    case (ex_funct3)
      F3_B, F3_BU: begin
        dmem_be    = 4'b0001 << ex_ALUResult[1:0];
        dmem_wdata = {4{ex_WriteData[7:0]}};
      end
      F3_H, F3_HU: begin
        dmem_be    = ex_ALUResult[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{ex_WriteData[15:0]}};
      end
      default: dmem_be = 4'b1111;
    endcase
    if (!dmem_req) dmem_be = 4'b0000;
  end

  // FSM plus MEM/WB register; control is zeroed on stall, misalign or no-valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      memwb.ctrl  <= '0;
      memwb.data  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (dmem_req && dmem_gnt && !ex_MemWrite) state <= ST_RESP;
        ST_RESP: if (dmem_rvalid) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (ex_valid && !stall_o && !misalign_o)
        memwb.ctrl <= memwb_ctrl_t'{reg_write: ex_RegWrite, result_src: ex_ResultSrc};
      else
        memwb.ctrl <= '0;
      memwb.data <= memwb_data_t'{
        alu_result: ex_ALUResult,
        load_data:  (!idle && dmem_rvalid) ? load_ext : '0,
        imm_ext:    ex_ImmExt,
        pc_plus4:   ex_PCPlus4,
        rd:         ex_Rd
      };
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: per-cycle expected MEM/WB contents are queued
// as stimulus is applied and compared after the clock edge.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_RegWrite, ex_MemWrite;
  logic [1:0]  ex_ResultSrc;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_ALUResult, ex_WriteData, ex_ImmExt, ex_PCPlus4;
  logic [4:0]  ex_Rd;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall_o, misalign_o;

  memwb_if mw ();

  mem_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite),
    .ex_ResultSrc(ex_ResultSrc), .ex_MemWrite(ex_MemWrite), .ex_funct3(ex_funct3),
    .ex_ALUResult(ex_ALUResult), .ex_WriteData(ex_WriteData), .ex_ImmExt(ex_ImmExt),
    .ex_PCPlus4(ex_PCPlus4), .ex_Rd(ex_Rd), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall_o(stall_o), .misalign_o(misalign_o), .memwb(mw)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] alu, ld, imm, pc4;
    logic [4:0]  rd;
    logic        chk;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] rs, input logic we,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd);
    ex_valid     = v;
    ex_RegWrite  = rw;
    ex_ResultSrc = rs;
    ex_MemWrite  = we;
    ex_funct3    = f3;
    ex_ALUResult = alu;
    ex_WriteData = wd;
    ex_ImmExt    = {alu[15:0], 16'h1111};
    ex_PCPlus4   = 32'h0000_1000 + alu;
    ex_Rd        = rd;
  endtask

  // Check combinational outputs, queue the expected MEM/WB, clock, then compare.
  task automatic cycle(input string tag, input logic e_req, input logic e_stall,
                       input logic e_mis, input logic e_rw, input logic [1:0] e_rs,
                       input logic [31:0] e_ld, input logic chk);
    exp_t e, g;
    #2;
    check({tag, ".req"},      64'(dmem_req),   64'(e_req));
    check({tag, ".stall"},    64'(stall_o),    64'(e_stall));
    check({tag, ".misalign"}, 64'(misalign_o), 64'(e_mis));
    e.tag = tag;
    e.rw  = e_rw;
    e.rs  = e_rs;
    e.ld  = e_ld;
    e.chk = chk;
    e.alu = rst_n ? ex_ALUResult : 32'h0;
    e.imm = rst_n ? ex_ImmExt    : 32'h0;
    e.pc4 = rst_n ? ex_PCPlus4   : 32'h0;
    e.rd  = rst_n ? ex_Rd        : 5'h0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check({g.tag, ".ctrl"}, 64'({mw.ctrl.reg_write, mw.ctrl.result_src}), 64'({g.rw, g.rs}));
    if (g.chk) begin
      check({g.tag, ".alu"},  64'(mw.data.alu_result), 64'(g.alu));
      check({g.tag, ".ld"},   64'(mw.data.load_data),  64'(g.ld));
      check({g.tag, ".imm"},  64'(mw.data.imm_ext),    64'(g.imm));
      check({g.tag, ".pc4"},  64'(mw.data.pc_plus4),   64'(g.pc4));
      check({g.tag, ".rd"},   64'(mw.data.rd),         64'(g.rd));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    dmem_gnt = 1'b1; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    drive(1, 1, RS_LOAD, 0, F3_W, 32'h400, 32'h0, 5'd3);
    cycle("rst0", 0, 0, 0, 0, 2'b00, 32'h0, 1);
    check("rst.we", 64'(dmem_we), 64'(0));
    cycle("rst1", 0, 0, 0, 0, 2'b00, 32'h0, 1);

    // ALU op with stray rvalid/gnt that must be ignored
    rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    drive(1, 1, 2'b00, 0, F3_W, 32'h10, 32'h0, 5'd5);
    cycle("add", 0, 0, 0, 1, 2'b00, 32'h0, 1);
    dmem_rvalid = 1'b0; dmem_gnt = 1'b0;

    // LB 0x103, granted immediately, response next cycle
    drive(1, 1, RS_LOAD, 0, F3_B, 32'h103, 32'h0, 5'd7);
    dmem_gnt = 1'b1;
    #2;
    check("lb.addr", 64'(dmem_addr), 64'(32'h100));
    check("lb.we",   64'(dmem_we),   64'(0));
    cycle("lb.req", 1, 1, 0, 0, 2'b00, 32'h0, 0);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_FFFF;
    cycle("lb.rsp", 0, 0, 0, 1, RS_LOAD, 32'hFFFF_FF80, 1);
    dmem_rvalid = 1'b0;

    // SH 0x202 with grant two cycles late
    drive(1, 0, 2'b00, 1, F3_H, 32'h202, 32'h1234_ABCD, 5'd0);
    #2;
    check("sh.be",    64'(dmem_be),    64'(4'b1100));
    check("sh.wdata", 64'(dmem_wdata), 64'(32'hABCD_ABCD));
    check("sh.we",    64'(dmem_we),    64'(1));
    check("sh.addr",  64'(dmem_addr),  64'(32'h200));
    cycle("sh.wait0", 1, 1, 0, 0, 2'b00, 32'h0, 0);
    cycle("sh.wait1", 1, 1, 0, 0, 2'b00, 32'h0, 0);
    dmem_gnt = 1'b1;
    cycle("sh.gnt", 1, 0, 0, 0, 2'b00, 32'h0, 1);

    // SB 0x101 and SW 0x300, granted at once
    drive(1, 0, 2'b00, 1, F3_B, 32'h101, 32'h5566_7788, 5'd0);
    #2;
    check("sb.be",    64'(dmem_be),    64'(4'b0010));
    check("sb.wdata", 64'(dmem_wdata), 64'(32'h8888_8888));
    cycle("sb", 1, 0, 0, 0, 2'b00, 32'h0, 1);
    drive(1, 0, 2'b00, 1, F3_W, 32'h300, 32'hCAFE_F00D, 5'd0);
    #2;
    check("sw.be",    64'(dmem_be),    64'(4'b1111));
    check("sw.wdata", 64'(dmem_wdata), 64'(32'hCAFE_F00D));
    cycle("sw", 1, 0, 0, 0, 2'b00, 32'h0, 1);

    // Misaligned LW and LH: dropped, no stall
    drive(1, 1, RS_LOAD, 0, F3_W, 32'h301, 32'h0, 5'd8);
    cycle("lw.mis", 0, 0, 1, 0, 2'b00, 32'h0, 0);
    drive(1, 1, RS_LOAD, 0, F3_H, 32'h105, 32'h0, 5'd8);
    cycle("lh.mis", 0, 0, 1, 0, 2'b00, 32'h0, 0);

    // LHU 0x2
    drive(1, 1, RS_LOAD, 0, F3_HU, 32'h2, 32'h0, 5'd9);
    cycle("lhu.req", 1, 1, 0, 0, 2'b00, 32'h0, 0);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hF00D_0000;
    cycle("lhu.rsp", 0, 0, 0, 1, RS_LOAD, 32'h0000_F00D, 1);
    dmem_rvalid = 1'b0; dmem_gnt = 1'b1;

    // LH 0x2 with response one cycle late
    drive(1, 1, RS_LOAD, 0, F3_H, 32'h2, 32'h0, 5'd10);
    cycle("lh.req", 1, 1, 0, 0, 2'b00, 32'h0, 0);
    dmem_gnt = 1'b0;
    cycle("lh.wait", 0, 1, 0, 0, 2'b00, 32'h0, 0);
    dmem_rvalid = 1'b1;
    cycle("lh.rsp", 0, 0, 0, 1, RS_LOAD, 32'hFFFF_F00D, 1);
    dmem_rvalid = 1'b0; dmem_gnt = 1'b1;

    // LBU 0x1
    drive(1, 1, RS_LOAD, 0, F3_BU, 32'h1, 32'h0, 5'd11);
    cycle("lbu.req", 1, 1, 0, 0, 2'b00, 32'h0, 0);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_8000;
    cycle("lbu.rsp", 0, 0, 0, 1, RS_LOAD, 32'h0000_0080, 1);
    dmem_rvalid = 1'b0;

    // No live instruction
    drive(0, 1, RS_LOAD, 0, F3_W, 32'h44, 32'h0, 5'd12);
    cycle("novalid", 0, 0, 0, 0, 2'b00, 32'h0, 0);

    // Reset while waiting for a load response; late rvalid must be ignored
    dmem_gnt = 1'b1;
    drive(1, 1, RS_LOAD, 0, F3_W, 32'h400, 32'h0, 5'd13);
    cycle("lwr.req", 1, 1, 0, 0, 2'b00, 32'h0, 0);
    rst_n = 1'b0; dmem_gnt = 1'b0;
    cycle("lwr.rst", 0, 0, 0, 0, 2'b00, 32'h0, 1);
    rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    drive(0, 0, 2'b00, 0, F3_W, 32'h400, 32'h0, 5'd13);
    cycle("lwr.late", 0, 0, 0, 0, 2'b00, 32'h0, 1);
    dmem_rvalid = 1'b0;
    cycle("lwr.idle", 0, 0, 0, 0, 2'b00, 32'h0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
